// File: rtl/wisc_pkg.sv
// wisc_pkg: shared constants and types for the 16-bit pipeline.
//   OPC_HLT      - opcode of the halt instruction (instr[15:12])
//   NOP_INSTR    - bubble instruction (ADD R0,R0,R0)
//   PC_RESET     - program counter value after reset
//   fetch_state_t- fetch stage FSM encoding
//   PC_SEL_*     - select codes for fetch_pc_reg
package wisc_pkg;

    localparam logic [3:0]  OPC_HLT   = 4'hF;
    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [15:0] PC_RESET  = 16'h0000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam logic [1:0] PC_SEL_HOLD = 2'd0;
    localparam logic [1:0] PC_SEL_LOAD = 2'd1;
    localparam logic [1:0] PC_SEL_INCR = 2'd2;

    function automatic logic is_hlt(input logic [15:0] instr);
        return instr[15:12] == OPC_HLT;
    endfunction

endpackage

// File: rtl/dff.sv
// dff: plain register with synchronous active-high reset.
//   clk - clock
//   rst - synchronous reset, loads RST_VAL
//   d   - next value
//   q   - registered value
module dff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: 16-bit program counter with hold / load / increment select.
//   clk      - clock
//   rst      - synchronous reset to PC_RESET
//   sel      - PC_SEL_HOLD, PC_SEL_LOAD or PC_SEL_INCR
//   load_val - value taken on PC_SEL_LOAD (caller supplies an even address)
//   pc       - current program counter
module fetch_pc_reg
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sel,
    input  logic [15:0] load_val,
    output logic [15:0] pc
);

    logic [15:0] pc_d;

    // Increment wraps modulo 2^16: FFFE + 2 = 0000.
    always_comb begin
        pc_d = pc;
        case (sel)
            PC_SEL_LOAD: pc_d = load_val;
            PC_SEL_INCR: pc_d = pc + 16'd2;
            default:     pc_d = pc;
        endcase
    end

    dff #(.WIDTH(16), .RST_VAL(PC_RESET)) u_pc_ff (
        .clk (clk),
        .rst (rst),
        .d   (pc_d),
        .q   (pc)
    );

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage; owns the PC and the IF/ID register and
// fetches over a req/rdy handshake that tolerates wait states.
//   clk, rst              - clock, synchronous active-high reset
//   stall, flush, hlt     - from hazard_detection
//   br_taken, br_target   - branch redirect (target bit 0 ignored)
//   imem_req, imem_addr   - fetch request / address (held while waiting)
//   imem_rdy, imem_data   - fetch completion / instruction
//   if_id_instr/pc/pc2    - IF/ID instruction, its address, address + 2
//   if_id_valid           - IF/ID holds a real instruction
//   halted                - sticky halt indication
//   stall_cnt             - cycles IF/ID did not advance; only when the
//                           FETCH_STALL_CNT_EN macro is defined
//
// state  | meaning
// FETCH  | request issued this cycle (unless stalled or draining a HLT)
// WAIT   | request outstanding, imem_rdy was low
// HOLD   | HLT latched in IF/ID, no requests issued
// HALTED | halt confirmed; left only by rst
module fetch_stage
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        hlt,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic [15:0] if_id_pc2,
    output logic        if_id_valid,
    output logic        halted
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    fetch_state_t state, state_d;

    logic [15:0] pc;
    logic [1:0]  pc_sel;
    logic [15:0] pc_load_val;

    logic        skid_valid;
    logic [15:0] skid_instr;
    logic [15:0] skid_pc;
    logic        redirect_pend;
    logic [15:0] redirect_tgt;

    logic        ifid_load, ifid_bubble;
    logic [15:0] ifid_instr_d, ifid_pc_d;
    logic        skid_clr, skid_capture, skid_drain;
    logic        pend_d;
    logic [15:0] tgt_d;
    logic        outstanding;
    logic [15:0] redirect_addr;

    fetch_pc_reg u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .sel      (pc_sel),
        .load_val (pc_load_val),
        .pc       (pc)
    );

    // A buffered HLT is not followed by a new request: the stage goes to HOLD.
    assign imem_req = (state == WAIT) ||
                      ((state == FETCH) && !stall && !(skid_valid && is_hlt(skid_instr)));
    assign imem_addr     = pc;
    assign outstanding   = imem_req && !imem_rdy;
    assign redirect_addr = br_taken ? (br_target & 16'hFFFE) : if_id_pc;

    assign if_id_pc2 = if_id_pc + 16'd2;
    assign halted    = (state == HALTED);

    always_comb begin
        state_d      = state;
        pc_sel       = PC_SEL_HOLD;
        pc_load_val  = redirect_addr;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_instr_d = imem_data;
        ifid_pc_d    = pc;
        skid_clr     = 1'b0;
        skid_capture = 1'b0;
        skid_drain   = 1'b0;
        pend_d       = redirect_pend;
        tgt_d        = redirect_tgt;

        case (state)
            FETCH, WAIT: begin
                if (br_taken || flush) begin
                    ifid_bubble = 1'b1;
                    skid_clr    = 1'b1;
                    if (outstanding) begin
                        // Memory still owes data for the old address; keep
                        // the address stable and redirect once it returns.
                        pend_d  = 1'b1;
                        tgt_d   = redirect_addr;
                        state_d = WAIT;
                    end else begin
                        pc_sel  = PC_SEL_LOAD;
                        pend_d  = 1'b0;
                        state_d = FETCH;
                    end
                end else if (redirect_pend) begin
                    if (imem_rdy) begin
                        pc_sel      = PC_SEL_LOAD;
                        pc_load_val = redirect_tgt;
                        pend_d      = 1'b0;
                        state_d     = FETCH;
                    end
                end else if (stall) begin
                    if ((state == WAIT) && imem_rdy) begin
                        skid_capture = 1'b1;
                        pc_sel       = PC_SEL_INCR;
                        state_d      = FETCH;
                    end
                end else if (skid_valid) begin
                    ifid_load    = 1'b1;
                    ifid_instr_d = skid_instr;
                    ifid_pc_d    = skid_pc;
                    skid_drain   = 1'b1;
                    if (is_hlt(skid_instr)) begin
                        state_d = HOLD;
                    end else if (imem_rdy) begin
                        // The skid entry moves to IF/ID while the new word
                        // refills it, keeping one instruction per cycle.
                        skid_capture = 1'b1;
                        pc_sel       = PC_SEL_INCR;
                        state_d      = FETCH;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (imem_rdy) begin
                    ifid_load = 1'b1;
                    pc_sel    = PC_SEL_INCR;
                    state_d   = is_hlt(imem_data) ? HOLD : FETCH;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (br_taken || flush) begin
                    ifid_bubble = 1'b1;
                    skid_clr    = 1'b1;
                    pc_sel      = PC_SEL_LOAD;
                    state_d     = FETCH;
                end else if (hlt) begin
                    state_d = HALTED;
                end
            end
            default: state_d = HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FETCH;
            if_id_instr   <= NOP_INSTR;
            if_id_pc      <= PC_RESET;
            if_id_valid   <= 1'b0;
            skid_valid    <= 1'b0;
            skid_instr    <= NOP_INSTR;
            skid_pc       <= PC_RESET;
            redirect_pend <= 1'b0;
            redirect_tgt  <= PC_RESET;
        end else begin
            state         <= state_d;
            redirect_pend <= pend_d;
            redirect_tgt  <= tgt_d;

            if (ifid_bubble) begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end else if (ifid_load) begin
                if_id_instr <= ifid_instr_d;
                if_id_pc    <= ifid_pc_d;
                if_id_valid <= 1'b1;
            end

            if (skid_clr) begin
                skid_valid <= 1'b0;
            end else if (skid_capture) begin
                skid_valid <= 1'b1;
                skid_instr <= imem_data;
                skid_pc    <= pc;
            end else if (skid_drain) begin
                skid_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic cnt_inc;
    assign cnt_inc = (state != HALTED) && !ifid_load && !ifid_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
        end else if (cnt_inc && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import wisc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, hlt = 1'b0, br_taken = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] if_id_instr, if_id_pc, if_id_pc2;
    logic        if_id_valid, halted;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .hlt         (hlt),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_data   (imem_data),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_pc2   (if_id_pc2),
        .if_id_valid (if_id_valid),
        .halted      (halted)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st, fl, hl, br;
        logic [15:0] tgt;
        logic        rdy;
        logic [15:0] data;
        logic        e_req;
        logic [15:0] e_addr, e_instr, e_pc;
        logic        e_valid, e_halted;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   row   = -1;

    task automatic add(input logic st, input logic fl, input logic hl, input logic br,
                       input logic [15:0] tgt, input logic rdy, input logic [15:0] data,
                       input logic e_req, input logic [15:0] e_addr, input logic [15:0] e_instr,
                       input logic [15:0] e_pc, input logic e_valid, input logic e_halted);
        vec_t v;
        v.st = st; v.fl = fl; v.hl = hl; v.br = br; v.tgt = tgt; v.rdy = rdy; v.data = data;
        v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc = e_pc;
        v.e_valid = e_valid; v.e_halted = e_halted;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %h, expected %h", nm, row, act, exp);
        end
    endtask

    initial begin
        //  st fl hl br tgt       rdy data      req addr      instr     pc        v  h
        add(0, 0, 0, 0, 16'h0000, 1, 16'h1234, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 16'h5678, 1, 16'h0002, 16'h1234, 16'h0000, 1, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 16'h5678, 16'h0002, 1, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 16'h5678, 16'h0002, 1, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 16'h9ABC, 1, 16'h0004, 16'h5678, 16'h0002, 1, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 16'h9ABC, 16'h0004, 1, 0);
        add(0, 0, 0, 1, 16'h0041, 0, 16'h0000, 1, 16'h0006, 16'h9ABC, 16'h0004, 1, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 16'hDEAD, 1, 16'h0006, 16'h0000, 16'h0004, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0040, 16'h0000, 16'h0004, 0, 0);
        add(0, 0, 0, 1, 16'h000E, 1, 16'hBEEF, 1, 16'h0042, 16'h1111, 16'h0040, 1, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 16'h2222, 1, 16'h000E, 16'h0000, 16'h0040, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 16'h3333, 1, 16'h0010, 16'h2222, 16'h000E, 1, 0);
        add(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0012, 16'h3333, 16'h0010, 1, 0);
        add(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0012, 16'h3333, 16'h0010, 1, 0);
        add(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0012, 16'h3333, 16'h0010, 1, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 16'h3333, 1, 16'h0010, 16'h0000, 16'h0010, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0012, 16'h3333, 16'h0010, 1, 0);
        add(1, 0, 0, 0, 16'h0000, 1, 16'h4444, 1, 16'h0012, 16'h3333, 16'h0010, 1, 0);
        add(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0014, 16'h3333, 16'h0010, 1, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 16'h5555, 1, 16'h0014, 16'h3333, 16'h0010, 1, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0016, 16'h4444, 16'h0012, 1, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 16'h6666, 1, 16'h0016, 16'h5555, 16'h0014, 1, 0);
        add(0, 0, 0, 1, 16'h0020, 1, 16'h7777, 1, 16'h0018, 16'h6666, 16'h0016, 1, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 16'hF000, 1, 16'h0020, 16'h0000, 16'h0016, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0022, 16'hF000, 16'h0020, 1, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0022, 16'hF000, 16'h0020, 1, 0);
        add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0022, 16'hF000, 16'h0020, 1, 0);
        add(0, 0, 0, 1, 16'h0100, 1, 16'h0000, 0, 16'h0022, 16'hF000, 16'h0020, 1, 1);
        add(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0022, 16'hF000, 16'h0020, 1, 1);
        add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0022, 16'hF000, 16'h0020, 1, 1);

        // Reset state, sampled while rst is still asserted.
        repeat (2) @(negedge clk);
        #1;
        chk("reset_pc2",    if_id_pc2, 16'h0002);
        chk("reset_halted", {15'b0, halted}, 16'h0000);
        chk("reset_valid",  {15'b0, if_id_valid}, 16'h0000);

        foreach (vecs[i]) begin
            @(negedge clk);
            row       = i;
            rst       = 1'b0;
            stall     = vecs[i].st;
            flush     = vecs[i].fl;
            hlt       = vecs[i].hl;
            br_taken  = vecs[i].br;
            br_target = vecs[i].tgt;
            imem_rdy  = vecs[i].rdy;
            imem_data = vecs[i].data;
            #1;
            chk("imem_req",    {15'b0, imem_req},    {15'b0, vecs[i].e_req});
            chk("imem_addr",   imem_addr,            vecs[i].e_addr);
            chk("if_id_instr", if_id_instr,          vecs[i].e_instr);
            chk("if_id_pc",    if_id_pc,             vecs[i].e_pc);
            chk("if_id_valid", {15'b0, if_id_valid}, {15'b0, vecs[i].e_valid});
            chk("halted",      {15'b0, halted},      {15'b0, vecs[i].e_halted});
        end

        // Reset out of HALTED, then redirect to FFFE and check the wrap.
        row = 100;
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; flush = 1'b0; hlt = 1'b0; br_taken = 1'b0; imem_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0; br_taken = 1'b1; br_target = 16'hFFFF; imem_rdy = 1'b1; imem_data = 16'h0000;
        #1;
        chk("rst_halted", {15'b0, halted}, 16'h0000);
        chk("rst_addr",   imem_addr, 16'h0000);
        chk("rst_instr",  if_id_instr, NOP_INSTR);
        chk("rst_req",    {15'b0, imem_req}, 16'h0001);
`ifdef FETCH_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 16'h0000);
`endif
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            row = 101 + k;
            br_taken = 1'b0; stall = 1'b1; imem_rdy = 1'b0;
            #1;
            chk("wrap_stall_addr", imem_addr, 16'hFFFE);
            chk("wrap_stall_req",  {15'b0, imem_req}, 16'h0000);
        end
        @(negedge clk);
        row = 106;
        stall = 1'b0; imem_rdy = 1'b1; imem_data = 16'hABCD;
        #1;
        chk("wrap_req", {15'b0, imem_req}, 16'h0001);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 16'h0005);
`endif
        @(negedge clk);
        row = 107;
        imem_rdy = 1'b0;
        #1;
        chk("wrap_instr", if_id_instr, 16'hABCD);
        chk("wrap_pc",    if_id_pc,    16'hFFFE);
        chk("wrap_pc2",   if_id_pc2,   16'h0000);
        chk("wrap_addr",  imem_addr,   16'h0000);
        chk("wrap_valid", {15'b0, if_id_valid}, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
